// File: rtl/genetic_pkg.sv
// Shared geometry of the evolvable LUT array and the evaluation sequencer.
// Everything that sizes a chromosome, a fitness score or the FSM lives here.
package genetic_pkg;

    localparam int ROW = 2;
    localparam int COL = 2;
    localparam int IN  = 2;
    localparam int OUT = 1;

    localparam int SEL_W   = $clog2(ROW * COL);
    localparam int CHROM_W = ROW * COL * 16 + SEL_W * OUT;
    localparam int FIT_W   = $clog2((2 ** IN) * OUT + 1);

    localparam int WORD_W_DEF = 8;

    function automatic int chrom_words(input int word_w);
        return (CHROM_W + word_w - 1) / word_w;
    endfunction

    localparam int NWORDS = chrom_words(WORD_W_DEF);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        EV_IDLE  = ST_IDLE,
        EV_LOAD  = ST_LOAD,
        EV_EVAL  = ST_EVAL,
        EV_DRAIN = ST_DRAIN,
        EV_DONE  = ST_DONE
    } eval_state_t;

endpackage

// File: rtl/chrom_eval_ctrl_if.sv
// Host-side link of the evaluation sequencer: start, serial chromosome load,
// target truth table and the fitness result.
interface chrom_eval_ctrl_if
    import genetic_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();

    logic                      start;
    logic                      load_valid;
    logic [WORD_W-1:0]         load_data;
    logic                      load_ready;
    logic [(2**IN)*OUT-1:0]    target;
    logic                      busy;
    logic                      done;
    logic [FIT_W-1:0]          fitness;

    modport master (
        output start, load_valid, load_data, target,
        input  load_ready, busy, done, fitness
    );

    modport slave (
        input  start, load_valid, load_data, target,
        output load_ready, busy, done, fitness
    );

endinterface

// File: rtl/fitness_acc.sv
// Capture register plus compare stage: one cycle after each capture the
// number of matching output bits for that vector is added to acc.
module fitness_acc
    import genetic_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   cap_en,
    input  logic [OUT-1:0]         dp_out,
    input  logic [IN-1:0]          v,
    input  logic [(2**IN)*OUT-1:0] target,
    output logic [FIT_W-1:0]       acc
);

    logic                 cap_vld_q;
    logic [OUT-1:0]       cap_out_q;
    logic [IN-1:0]        cap_v_q;
    logic [FIT_W-1:0]     acc_q, acc_d;
    logic [OUT-1:0]       tgt_slice;
    logic [OUT-1:0]       miss;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        tgt_slice = target[cap_v_q*OUT +: OUT];
        miss      = cap_out_q ^ tgt_slice;
        acc_d     = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (cap_vld_q) begin
            acc_d = acc_q + FIT_W'(OUT - $countones(miss));
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_q <= 1'b0;
            cap_out_q <= '0;
            cap_v_q   <= '0;
            acc_q     <= '0;
        end else begin
            cap_vld_q <= cap_en;
            if (cap_en) begin
                cap_out_q <= dp_out;
                cap_v_q   <= v;
            end
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/chrom_eval_ctrl.sv
// Evaluation sequencer: loads a chromosome LSB-word-first, sweeps every input
// vector through the array and reports how many output bits hit the target.
module chrom_eval_ctrl
    import genetic_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chrom_eval_ctrl_if.slave     host,
    output logic [CHROM_W-1:0]   chrom,
    output logic [IN-1:0]        dp_inp,
    input  logic [OUT-1:0]       dp_out
);

    localparam int NW     = chrom_words(WORD_W);
    localparam int WCNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NW - 1);

    logic [2:0]          state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [IN-1:0]       v_q, v_d;
    logic [CHROM_W-1:0]  chrom_q, chrom_d;
    logic [FIT_W-1:0]    fitness_q, fitness_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs;
    logic                clr;
    logic                cap_en;
    logic [FIT_W-1:0]    acc;

    assign hs = (state_q == ST_LOAD) && host.load_valid;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        v_d       = v_q;
        chrom_d   = chrom_q;
        fitness_d = fitness_q;
        clr       = 1'b0;
        cap_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    wcnt_d    = '0;
                    v_d       = '0;
                    fitness_d = '0;
                    clr       = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    // Bits past CHROM_W in the final word have no home and drop out.
                    for (int i = 0; i < CHROM_W; i++) begin
                        if ((i / WORD_W) == int'(wcnt_q)) begin
                            chrom_d[i] = host.load_data[i % WORD_W];
                        end
                    end
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d  = '0;
                        v_d     = '0;
                        state_d = ST_EVAL;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                cap_en = 1'b1;
                if (v_q == '1) begin
                    state_d = ST_DRAIN;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                fitness_d = acc;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d == ST_LOAD) || (state_d == ST_EVAL) || (state_d == ST_DRAIN);
    assign done_d = (state_d == ST_DONE);

    // NOTE: chrom is a plain register, not a RAM, so it is reset with the rest;
    // an array memory would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            v_q       <= '0;
            chrom_q   <= '0;
            fitness_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            v_q       <= v_d;
            chrom_q   <= chrom_d;
            fitness_q <= fitness_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    fitness_acc u_fitness_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .cap_en (cap_en),
        .dp_out (dp_out),
        .v      (v_q),
        .target (host.target),
        .acc    (acc)
    );

    // The final score is shown straight from the accumulator in DONE, then held.
    assign host.fitness    = (state_q == ST_DONE) ? acc : fitness_q;
    assign host.load_ready = (state_q == ST_LOAD);
    assign host.busy       = busy_q;
    assign host.done       = done_q;
    assign chrom           = chrom_q;
    assign dp_inp          = v_q;

endmodule
